// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state, digit and LED pattern definitions for the alarm sequencer
package alarm_pkg;
    typedef enum logic [1:0] {DISABLED, ARMED, RING, SNOOZE} state_e;
    typedef logic [3:0] bcd_t;
    localparam logic [15:0] DEF_PAT_A = 16'hAAAA;
    localparam logic [15:0] DEF_PAT_B = 16'h5555;
endpackage

// File: rtl/alarm_time_match.sv
// alarm_time_match: HH:MM digit compare with a registered rising-edge hit detect
module alarm_time_match
    import alarm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       preload_i,
    input  bcd_t [3:0] time_i,
    input  bcd_t [3:0] alarm_i,
    output logic       hit_o
);
    logic match, match_q;
    assign match = (time_i == alarm_i);
    // preload suppresses the edge while the previous match value is being captured
    assign hit_o = match & ~match_q & ~preload_i;
    always_ff @(posedge clk) begin
        match_q <= reset ? 1'b0 : match;
    end
endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: arms, rings, snoozes and times out the alarm, driving the LED bank
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int          RING_SEC   = 60,
    parameter int          SNOOZE_SEC = 300,
    parameter int          MAX_SNOOZE = 3,
    parameter logic [15:0] PAT_A      = DEF_PAT_A,
    parameter logic [15:0] PAT_B      = DEF_PAT_B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        alarm_enable,
    input  logic        stop_alarm,
    input  logic        snooze,
    input  logic [3:0]  first,
    input  logic [3:0]  second,
    input  logic [3:0]  third,
    input  logic [3:0]  fourth,
    input  logic [3:0]  a_first,
    input  logic [3:0]  a_second,
    input  logic [3:0]  a_third,
    input  logic [3:0]  a_fourth,
    output logic [15:0] led,
    output logic        ringing,
    output logic        snoozing,
    output logic [2:0]  snooze_left
);
    localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);
    localparam logic [9:0] SNZ_LAST  = 10'(SNOOZE_SEC - 1);
    localparam logic [2:0] SNZ_MAX   = 3'(MAX_SNOOZE);

    state_e      state_q, state_d;
    logic [7:0]  ring_cnt_q, ring_cnt_d;
    logic [9:0]  snz_cnt_q, snz_cnt_d;
    logic [2:0]  left_q, left_d;
    logic [15:0] led_q, led_d;
    logic        ringing_q, snoozing_q;
    logic        hit, ring_done, snz_done, snz_ok;

    alarm_time_match u_match (
        .clk       (clk),
        .reset     (reset),
        .preload_i (state_q == DISABLED),
        .time_i    ({fourth, third, second, first}),
        .alarm_i   ({a_fourth, a_third, a_second, a_first}),
        .hit_o     (hit)
    );

    assign ring_done = tick_1hz && ring_cnt_q >= RING_LAST;
    assign snz_done  = tick_1hz && snz_cnt_q >= SNZ_LAST;
    assign snz_ok    = snooze && left_q != '0;

    always_comb begin
        state_d = state_q;
        if (!alarm_enable)
            state_d = DISABLED;
        else
            case (state_q)
                DISABLED: state_d = ARMED;
                ARMED:    state_d = hit ? RING : ARMED;
                RING:     state_d = (stop_alarm || ring_done || (snooze && !snz_ok)) ? ARMED : snz_ok ? SNOOZE : RING;
                SNOOZE:   state_d = stop_alarm ? ARMED : snz_done ? RING : SNOOZE;
                default:  state_d = DISABLED;
            endcase
        // counters restart on the entry cycle, so a tick landing there is not counted
        ring_cnt_d = (state_q != RING) ? '0 : (tick_1hz && ring_cnt_q != '1) ? ring_cnt_q + 8'd1 : ring_cnt_q;
        snz_cnt_d  = (state_q != SNOOZE) ? '0 : (tick_1hz && snz_cnt_q != '1) ? snz_cnt_q + 10'd1 : snz_cnt_q;
        left_d     = (state_d == DISABLED || state_d == ARMED) ? SNZ_MAX :
                     (state_q == RING && state_d == SNOOZE) ? left_q - 3'd1 : left_q;
        led_d      = (state_d != RING) ? '0 : (state_q != RING) ? PAT_A :
                     tick_1hz ? ((led_q == PAT_A) ? PAT_B : PAT_A) : led_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DISABLED;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            left_q     <= SNZ_MAX;
            led_q      <= '0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            left_q     <= left_d;
            led_q      <= led_d;
            ringing_q  <= state_d == RING;
            snoozing_q <= state_d == SNOOZE;
        end
    end

    assign led         = led_q;
    assign ringing     = ringing_q;
    assign snoozing    = snoozing_q;
    assign snooze_left = left_q;
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: scenario tasks with a scoreboard of expected {ringing, snoozing, led, snooze_left}
module tb_alarm_sequencer;
    logic        clk = 1'b0, reset = 1'b1, tick_1hz = 1'b0, alarm_enable = 1'b0;
    logic        stop_alarm = 1'b0, snooze = 1'b0;
    logic [3:0]  first, second, third, fourth, a_first, a_second, a_third, a_fourth;
    logic [15:0] led;
    logic        ringing, snoozing;
    logic [2:0]  snooze_left;

    typedef struct {string name; logic [20:0] v;} exp_t;
    exp_t sb[$];
    int passed = 0, total = 0;

    alarm_sequencer dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .alarm_enable(alarm_enable),
        .stop_alarm(stop_alarm), .snooze(snooze),
        .first(first), .second(second), .third(third), .fourth(fourth),
        .a_first(a_first), .a_second(a_second), .a_third(a_third), .a_fourth(a_fourth),
        .led(led), .ringing(ringing), .snoozing(snoozing), .snooze_left(snooze_left)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_time(input logic [3:0] h1, input logic [3:0] h0, input logic [3:0] m1, input logic [3:0] m0);
        fourth = h1; third = h0; second = m1; first = m0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step(); end
    endtask

    task automatic expect_state(input string nm, input logic r, input logic s, input logic [15:0] l, input logic [2:0] k);
        sb.push_back('{nm, {r, s, l, k}});
    endtask

    function automatic logic [20:0] obs();
        return {ringing, snoozing, led, snooze_left};
    endfunction

    task automatic refire();
        set_time(0, 7, 3, 1); step();
        set_time(0, 7, 3, 0);
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1; alarm_enable = 1'b0;
        set_time(0, 7, 2, 9);
        a_fourth = 0; a_third = 7; a_second = 3; a_first = 0;
        expect_state("reset", 0, 0, 16'h0, 3); step(2);
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_ring();
        exp_t e;
        alarm_enable = 1'b1;
        expect_state("armed", 0, 0, 16'h0, 3); step();
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        set_time(0, 7, 3, 0);
        expect_state("ring_entry", 1, 0, 16'hAAAA, 3); step();
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        expect_state("ring_tick1", 1, 0, 16'h5555, 3); tick(1);
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        expect_state("ring_tick2", 1, 0, 16'hAAAA, 3); tick(1);
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    endtask

    task automatic test_snooze();
        exp_t e;
        snooze = 1'b1;
        expect_state("snooze_entry", 0, 1, 16'h0, 2); step(); snooze = 1'b0;
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        expect_state("snooze_299", 0, 1, 16'h0, 2); tick(299);
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        expect_state("snooze_expire", 1, 0, 16'hAAAA, 2); tick(1);
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    endtask

    task automatic test_max_snooze();
        exp_t e;
        snooze = 1'b1; step(); snooze = 1'b0;
        expect_state("snooze2_back", 1, 0, 16'hAAAA, 1); tick(300);
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        snooze = 1'b1; step(); snooze = 1'b0;
        expect_state("snooze3_back", 1, 0, 16'hAAAA, 0); tick(300);
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        snooze = 1'b1;
        expect_state("snooze_exhausted", 0, 0, 16'h0, 3); step(); snooze = 1'b0;
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    endtask

    task automatic test_timeout();
        exp_t e;
        refire();
        expect_state("timeout_entry", 1, 0, 16'hAAAA, 3); step();
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        expect_state("ring_59", 1, 0, 16'h5555, 3); tick(59);
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        expect_state("ring_60", 0, 0, 16'h0, 3); tick(1);
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        expect_state("no_refire", 0, 0, 16'h0, 3); tick(5);
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        refire(); step();
        snooze = 1'b1; step(); snooze = 1'b0;
        expect_state("ring_left2", 1, 0, 16'hAAAA, 2); tick(300);
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        stop_alarm = 1'b1; snooze = 1'b1;
        expect_state("stop_wins", 0, 0, 16'h0, 3); step(); stop_alarm = 1'b0; snooze = 1'b0;
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        refire(); stop_alarm = 1'b1;
        expect_state("hit_beats_stop", 1, 0, 16'hAAAA, 3); step(); stop_alarm = 1'b0;
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        stop_alarm = 1'b1;
        expect_state("stop", 0, 0, 16'h0, 3); step(); stop_alarm = 1'b0;
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    endtask

    task automatic test_disable();
        exp_t e;
        refire(); step();
        snooze = 1'b1; step(); snooze = 1'b0;
        expect_state("dis_snoozing", 0, 1, 16'h0, 2); step();
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        alarm_enable = 1'b0;
        expect_state("disabled", 0, 0, 16'h0, 3); step();
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        set_time(0, 7, 3, 1); step();
        set_time(0, 7, 3, 0); alarm_enable = 1'b1;
        expect_state("enable_in_minute", 0, 0, 16'h0, 3); step(4);
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    endtask

    task automatic test_reset_mid_ring();
        exp_t e;
        refire();
        expect_state("pre_reset_ring", 1, 0, 16'hAAAA, 3); step();
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        tick(1); reset = 1'b1;
        expect_state("reset_mid_ring", 0, 0, 16'h0, 3); step(); reset = 1'b0;
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
        expect_state("post_reset_quiet", 0, 0, 16'h0, 3); step(3);
        e = sb.pop_front(); total++;
        if (obs() !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs(), e.v); else passed++;
    endtask

    initial begin
        test_reset();
        test_ring();
        test_snooze();
        test_max_snooze();
        test_timeout();
        test_back_to_back();
        test_disable();
        test_reset_mid_ring();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
